// File: rtl/game_pkg.sv
// Shared game-state encoding so the HUD and screen muxes can decode the sequencer state
// without keeping their own copy of the encoding.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PLAY,
    HIT,
    CLEAR,
    WIN,
    LOSE
  } game_st_t;

  // HIT and CLEAR both hold for a fixed number of tick strobes before moving on.
  function automatic logic isPauseState(game_st_t s);
    return (s == HIT) || (s == CLEAR);
  endfunction

endpackage

// File: rtl/game_timer.sv
// Loadable tick-driven down-counter used for the per-level time budget.
// Counts down only while enabled, never goes below zero.
module game_timer #(
  parameter int MAX = 60,
  parameter int W   = $clog2(MAX + 1)
)(
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  input  logic         tick,
  output logic [W-1:0] count,
  output logic         zero
);

  localparam logic [W-1:0] FULL = W'(MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= FULL;
    end else if (load) begin
      count <= FULL;
    end else if (en && tick && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/game_flow_ctrl.sv
// Top-level game sequencer: walks idle -> load -> play -> pause -> next level/retry -> win/lose,
// and owns the lives count, level index and level timer.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int NUM_LEVELS  = 4,
  parameter int NUM_LIVES   = 3,
  parameter int LEVEL_TICKS = 60,
  parameter int PAUSE_TICKS = 2,
  localparam int LVW = $clog2(NUM_LEVELS + 1),
  localparam int LFW = $clog2(NUM_LIVES + 1),
  localparam int TW  = $clog2(LEVEL_TICKS + 1)
)(
  input  logic           clk,
  input  logic           reset,
  input  logic           tick,
  input  logic           startKey,
  input  logic           charHit,
  input  logic           levelClear,
  output logic           start,
  output logic           gameOn,
  output logic [LVW-1:0] level,
  output logic [LFW-1:0] livesLeft,
  output logic [TW-1:0]  timeLeft,
  output logic           winScreen,
  output logic           loseScreen
);

  localparam int PW = $clog2(PAUSE_TICKS + 1);

  localparam logic [LVW-1:0] LAST_LEVEL = LVW'(NUM_LEVELS - 1);
  localparam logic [LFW-1:0] FULL_LIVES = LFW'(NUM_LIVES);
  localparam logic [PW-1:0]  PAUSE_LAST = PW'(PAUSE_TICKS - 1);

  game_st_t      state;
  game_st_t      stateNext;
  logic [PW-1:0] pauseCnt;
  logic          startKeyPrev;
  logic          startRise;
  logic          timerZero;
  logic          miss;
  logic          pauseDone;
  logic          inPause;

  game_timer #(
    .MAX (LEVEL_TICKS),
    .W   (TW)
  ) levelTimer (
    .clk   (clk),
    .reset (reset),
    .load  (state == LOAD),
    .en    (state == PLAY),
    .tick  (tick),
    .count (timeLeft),
    .zero  (timerZero)
  );

  // A timeout is seen one cycle after the timer reaches zero, since zero comes from the register.
  assign miss      = charHit | timerZero;
  assign inPause   = isPauseState(state);
  assign pauseDone = inPause && tick && (pauseCnt == PAUSE_LAST);
  assign startRise = startKey & ~startKeyPrev;

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:  if (startKey) stateNext = LOAD;
      LOAD:  stateNext = PLAY;
      PLAY: begin
        if (miss) begin
          stateNext = HIT;
        end else if (levelClear) begin
          stateNext = CLEAR;
        end
      end
      HIT:   if (pauseDone) stateNext = (livesLeft == '0) ? LOSE : LOAD;
      CLEAR: if (pauseDone) stateNext = (level == LAST_LEVEL) ? WIN : LOAD;
      WIN,
      LOSE:  if (startRise) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      level        <= '0;
      livesLeft    <= FULL_LIVES;
      pauseCnt     <= '0;
      startKeyPrev <= 1'b0;
    end else begin
      state        <= stateNext;
      startKeyPrev <= startKey;

      if (inPause) begin
        if (tick) pauseCnt <= pauseCnt + PW'(1);
      end else begin
        pauseCnt <= '0;
      end

      if ((state == PLAY) && miss && (livesLeft != '0)) begin
        livesLeft <= livesLeft - LFW'(1);
      end

      if ((state == CLEAR) && pauseDone && (level != LAST_LEVEL)) begin
        level <= level + LVW'(1);
      end

      // Any way back into IDLE starts a fresh game.
      if (stateNext == IDLE) begin
        level     <= '0;
        livesLeft <= FULL_LIVES;
      end
    end
  end

  assign start      = (state == LOAD);
  assign gameOn     = (state == PLAY);
  assign winScreen  = (state == WIN);
  assign loseScreen = (state == LOSE);

endmodule
